// File: rtl/stopwatch_bcd_core_pkg.sv
// Shared display definitions: blank code, field limit, core states and the
// digit order agreed between the counting core and the seven-segment driver.
package stopwatch_bcd_core_pkg;

  // Any code above 9 renders as all segments off in the driver.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Largest value held by the MM and SS fields.
  localparam int unsigned FIELD_MAX = 59;

  // Digit positions, rightmost first.
  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } sw_state_e;

endpackage

// File: rtl/stopwatch_bcd_core_bcd_mod60_counter.sv
// Two-digit BCD counter (tens/ones) wrapping from MAX_VALUE back to 00.
// carry_out flags the wrapping increment so a following field can advance.
import stopwatch_bcd_core_pkg::*;

module bcd_mod60_counter #(
  parameter int unsigned MAX_VALUE = FIELD_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_VALUE / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_VALUE % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  // Next digit values: wrap at the field maximum, ones 9 carries into tens.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    at_max = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    if (inc) begin
      if (at_max) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers with synchronous reset to 00.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens      = tens_q;
  assign ones      = ones_q;
  assign carry_out = inc && at_max;

endmodule

// File: rtl/stopwatch_bcd_core.sv
// MM:SS stopwatch core: run/pause, per-field adjust with blinking, and the
// four BCD digits for the seven-segment driver. All timing comes from
// single-cycle tick enables on display_clk.
module stopwatch_bcd_core #(
  parameter logic [3:0]  BLANK_CODE = stopwatch_bcd_core_pkg::BLANK_CODE,
  parameter int unsigned FIELD_MAX  = stopwatch_bcd_core_pkg::FIELD_MAX
) (
  input  logic       display_clk,
  input  logic       i_rst,
  input  logic       i_tick_1hz,
  input  logic       i_tick_2hz,
  input  logic       i_tick_blink,
  input  logic       i_pause,
  input  logic       i_adj,
  input  logic       i_sel,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic       o_running
);

  import stopwatch_bcd_core_pkg::*;

  sw_state_e  state_q, state_d;
  logic       run_q, run_d;
  logic       blink_q, blink_d;
  logic       sel_q;

  logic       ss_inc, mm_inc;
  logic       ss_carry, mm_carry_unused;
  logic [3:0] ss_tens, ss_ones, mm_tens, mm_ones;
  logic       blank_ss, blank_mm;
  logic [3:0] digits [0:3];

  // Field increments use the registered state, so a tick coinciding with a
  // mode or pause change is handled with the pre-change behaviour.
  always_comb begin
    ss_inc = ((state_q == ST_RUN) && i_tick_1hz) ||
             ((state_q == ST_ADJUST) && i_tick_2hz && i_sel);
    mm_inc = ((state_q == ST_RUN) && ss_carry) ||
             ((state_q == ST_ADJUST) && i_tick_2hz && !i_sel);
  end

  bcd_mod60_counter #(.MAX_VALUE(FIELD_MAX)) u_ss (
    .clk       (display_clk),
    .rst       (i_rst),
    .inc       (ss_inc),
    .tens      (ss_tens),
    .ones      (ss_ones),
    .carry_out (ss_carry)
  );

  bcd_mod60_counter #(.MAX_VALUE(FIELD_MAX)) u_mm (
    .clk       (display_clk),
    .rst       (i_rst),
    .inc       (mm_inc),
    .tens      (mm_tens),
    .ones      (mm_ones),
    .carry_out (mm_carry_unused)
  );

  // Next state, run flag and blink phase. The run flag toggles on i_pause in
  // every state so a pause issued while adjusting applies on exit.
  always_comb begin
    state_d = state_q;
    run_d   = run_q ^ i_pause;
    blink_d = blink_q;
    case (state_q)
      ST_RUN, ST_PAUSED: begin
        if (i_adj) begin
          state_d = ST_ADJUST;
          blink_d = 1'b0;
        end else begin
          state_d = run_d ? ST_RUN : ST_PAUSED;
        end
      end
      ST_ADJUST: begin
        if (i_tick_blink) blink_d = ~blink_q;
        if (!i_adj)       state_d = run_d ? ST_RUN : ST_PAUSED;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Control registers; reset returns to running at 00:00.
  always_ff @(posedge display_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      run_q   <= 1'b1;
      blink_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      blink_q <= blink_d;
      sel_q   <= i_sel;
    end
  end

  // Digit outputs from registered state only; the selected field blanks on
  // the active blink phase while adjusting.
  always_comb begin
    blank_ss = (state_q == ST_ADJUST) && blink_q && sel_q;
    blank_mm = (state_q == ST_ADJUST) && blink_q && !sel_q;
    digits[DIG_SEC_ONES] = blank_ss ? BLANK_CODE : ss_ones;
    digits[DIG_SEC_TENS] = blank_ss ? BLANK_CODE : ss_tens;
    digits[DIG_MIN_ONES] = blank_mm ? BLANK_CODE : mm_ones;
    digits[DIG_MIN_TENS] = blank_mm ? BLANK_CODE : mm_tens;
  end

  assign dig1      = digits[DIG_SEC_ONES];
  assign dig2      = digits[DIG_SEC_TENS];
  assign dig3      = digits[DIG_MIN_ONES];
  assign dig4      = digits[DIG_MIN_TENS];
  assign o_running = (state_q == ST_RUN);

endmodule
